// File: rtl/apu_cluster_package.sv
// Shared APU cluster definitions: floating-point datapath width and the
// widths of the div/sqrt rounding-mode and status-flag fields.
package apu_cluster_package;

    localparam int unsigned FP_WIDTH         = 32;
    localparam int unsigned NDSFLAGS_DIVSQRT = 3;
    localparam int unsigned NUSFLAGS_DIVSQRT = 5;

endpackage

// File: rtl/fp_divsqrt_req_fifo.sv
// Generic DEPTH-entry request FIFO in front of the div/sqrt unit.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push, wdata    write strobe and entry (caller guarantees !full)
//   pop            read strobe (caller guarantees !empty)
//   rdata          current head entry, combinational
//   full, empty    occupancy flags derived from the registered count
module fp_divsqrt_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fp_divsqrt_sequencer.sv
// Issue/retire sequencer for the shared iterative FP div/sqrt unit.
// Buffers requests, issues one at a time as a start pulse, tracks the tag of
// the op in flight, captures the unit's done pulse into a result register and
// hands the result to the consumer over valid/ready.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_*                      request channel into the FIFO
//   unit_en_o, unit_*_o        start pulse and FIFO head operands to the unit
//   unit_ready_i/valid_i/res_i/status_i  unit idle flag and completion
//   rsp_*                      response channel (result, flags, tag)
//
// state | meaning
// IDLE  | no op in flight, result register free
// BUSY  | op in flight, waiting for unit done pulse
// HOLD  | result held, rsp_valid_o asserted
module fp_divsqrt_sequencer
    import apu_cluster_package::*;
#(
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RND_WIDTH  = NDSFLAGS_DIVSQRT,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_DIVSQRT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [FP_WIDTH-1:0]   req_opa_i,
    input  logic [FP_WIDTH-1:0]   req_opb_i,
    input  logic                  req_sqrt_i,
    input  logic [RND_WIDTH-1:0]  req_rnd_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,

    output logic                  unit_en_o,
    output logic [FP_WIDTH-1:0]   unit_opa_o,
    output logic [FP_WIDTH-1:0]   unit_opb_o,
    output logic                  unit_sqrt_o,
    output logic [RND_WIDTH-1:0]  unit_rnd_o,
    input  logic                  unit_ready_i,
    input  logic                  unit_valid_i,
    input  logic [FP_WIDTH-1:0]   unit_res_i,
    input  logic [STAT_WIDTH-1:0] unit_status_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [FP_WIDTH-1:0]   rsp_res_o,
    output logic [STAT_WIDTH-1:0] rsp_status_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o
);

    localparam int unsigned ENTRY_W = 2 * FP_WIDTH + 1 + RND_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [FP_WIDTH-1:0]   res_q;
    logic [STAT_WIDTH-1:0] status_q;
    logic                  rsp_valid_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  issue;
    logic [ENTRY_W-1:0]    head;
    logic [TAG_WIDTH-1:0]  head_tag;

    // Ready depends only on registered occupancy, so a full FIFO does not
    // take a push even in a cycle where it is popped.
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i && !fifo_full;

    fp_divsqrt_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  ({req_opa_i, req_opb_i, req_sqrt_i, req_rnd_i, req_tag_i}),
        .pop    (issue),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign {unit_opa_o, unit_opb_o, unit_sqrt_o, unit_rnd_o, head_tag} = head;

    // HOLD may issue in the cycle the consumer takes the result, which keeps
    // the unit busy back-to-back.
    assign issue = !fifo_empty && unit_ready_i &&
                   ((state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready_i));

    assign unit_en_o = issue;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            tag_q       <= '0;
            res_q       <= '0;
            status_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= ST_BUSY;
                        tag_q <= head_tag;
                    end
                end
                ST_BUSY: begin
                    if (unit_valid_i) begin
                        state       <= ST_HOLD;
                        res_q       <= unit_res_i;
                        status_q    <= unit_status_i;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (issue) begin
                            state <= ST_BUSY;
                            tag_q <= head_tag;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_res_o    = res_q;
    assign rsp_status_o = status_q;
    assign rsp_tag_o    = tag_q;

endmodule

// File: doc/fp_divsqrt_sequencer.md
# fp_divsqrt_sequencer

Issue/retire sequencer placed directly in front of the shared iterative FP div/sqrt unit. It buffers incoming div/sqrt requests in a small FIFO and issues one request at a time as a single-cycle start pulse when the unit is ready. It keeps the tag of the operation in flight, captures the unit's one-cycle completion pulse into a result register, and presents that result to the consumer with a valid/ready handshake.

## Interface
Parameters:
- TAG_WIDTH, 5, request tag width.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- RND_WIDTH, NDSFLAGS_DIVSQRT, rounding-mode field width.
- STAT_WIDTH, NUSFLAGS_DIVSQRT, status-flag width.

Ports:
- clk_i  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  FIFO not full.
- req_opa_i / req_opb_i  in  FP_WIDTH each  operands (B unused for sqrt).
- req_sqrt_i  in  1  1 = sqrt, 0 = div.
- req_rnd_i  in  RND_WIDTH  rounding mode.
- req_tag_i  in  TAG_WIDTH  request tag.
- unit_en_o  out  1  start pulse to unit.
- unit_opa_o / unit_opb_o  out  FP_WIDTH each  FIFO head operands.
- unit_sqrt_o  out  1  FIFO head op select.
- unit_rnd_o  out  RND_WIDTH  FIFO head rounding mode.
- unit_ready_i  in  1  unit idle.
- unit_valid_i  in  1  one-cycle done pulse.
- unit_res_i  in  FP_WIDTH  result.
- unit_status_i  in  STAT_WIDTH  flags.
- rsp_valid_o  out  1  result held.
- rsp_ready_i  in  1  consumer accepts.
- rsp_res_o  out  FP_WIDTH  result.
- rsp_status_o  out  STAT_WIDTH  flags.
- rsp_tag_o  out  TAG_WIDTH  tag of the result.

## Operation
- FIFO push when req_valid_i & req_ready_o; req_ready_o = (count != DEPTH). Write/read pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- FSM states: IDLE (no op in flight, result register free), BUSY (op in flight), HOLD (result held, rsp_valid_o=1).
- issue = fifo_nonempty & unit_ready_i & (IDLE | (HOLD & rsp_ready_i)). unit_en_o = issue. On issue: pop FIFO, latch head tag into tag_q, go to BUSY.
- BUSY: on unit_valid_i, capture unit_res_i/unit_status_i into the result register and go to HOLD. No issue happens in BUSY.
- HOLD: on rsp_ready_i, go to IDLE, or to BUSY if issue fires the same cycle. rsp_tag_o = tag_q.
- unit_valid_i while in IDLE or HOLD is ignored; the result register is not overwritten.
- A push and a pop in the same cycle leave count unchanged. A full FIFO with a pop does not accept the same-cycle push, because req_ready_o is registered-state based.
- unit_op*_o, unit_sqrt_o and unit_rnd_o show the FIFO head combinationally. They are don't-care when unit_en_o=0.

## Timing
- Reset values: req_ready_o=1, unit_en_o=0, rsp_valid_o=0, rsp_res_o=0, rsp_status_o=0, rsp_tag_o=0. FSM is IDLE and FIFO is empty.
- Request accepted at cycle N: earliest unit_en_o at N+1 (no bypass).
- unit_valid_i at cycle M: rsp_valid_o=1 from M+1.
- Back-to-back ops: response accepted at cycle K with FIFO non-empty gives unit_en_o at K.
- Reset asserted mid-operation clears the FIFO, the FSM and all registers immediately. The unit shares rst_ni, so no stale completion is expected.

## Structure
- FP_WIDTH, NDSFLAGS_DIVSQRT and NUSFLAGS_DIVSQRT come from apu_cluster_package. The FSM state enum is local to the module.
- Sub-module fp_divsqrt_req_fifo holds the generic DEPTH-entry FIFO of {opa, opb, sqrt, rnd, tag}. The FSM and result register live in the top module.

## Test plan
- Div request 0x3F800000 / 0x40000000, tag 3. Unit model returns 0x3F000000 after 12 cycles → rsp_valid_o one cycle after done, rsp_res_o=0x3F000000, rsp_tag_o=3.
- Sqrt request opa=0x40800000, tag 7 → unit_sqrt_o=1 at issue, response 0x40000000 with tag 7.
- Push 5 requests with unit_ready_i=0 → req_ready_o low after the 4th. Release the unit → all 4 issue in order, tags preserved, and the 5th is accepted once space frees.
- Hold rsp_ready_i=0 for 20 cycles with the FIFO non-empty → no unit_en_o, response stable. Inject a spurious unit_valid_i → result unchanged. Raise rsp_ready_i → unit_en_o issues in the same cycle.
- Assert rst_ni=0 in BUSY with 2 queued requests → all outputs return to reset values and req_ready_o=1. Later unit_valid_i pulses in IDLE produce no response.
